uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Control FSM of the UART receiver. Sequences the edge/bit counter, data sampler, deserializer and start/parity/stop checkers over one frame, decides frame validity, and issues a one-cycle `data_valid`. Sits in the UART RX top beside those datapath blocks, driven by the oversampling clock.

## Interface
- `PRESCALE_WIDTH`, 6: width of `prescale` and `edge_cnt`.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk`  in  1  oversampling clock.
- `rst`  in  1  asynchronous reset, active low.
- `rx_in`  in  1  serial line, idle high.
- `par_en`  in  1  parity bit present.
- `prescale`  in  PRESCALE_WIDTH  oversampling ratio. Legal values: 8, 16, 32.
- `edge_cnt`  in  PRESCALE_WIDTH  from the edge/bit counter.
- `bit_cnt`  in  4  from the edge/bit counter. 0 = start bit, 1..DATA_BITS = data bits, then parity (if present), then stop.
- `strt_glitch`  in  1  start-checker result; valid at the check strobe.
- `par_err`  in  1  parity-checker result; valid at the check strobe.
- `stp_err`  in  1  stop-checker result; valid at the check strobe.
- `edge_bit_counter_enable`  out  1  counter run. Deasserting it clears the counter.
- `dat_samp_en`  out  1  sampler enable.
- `deser_en`  out  1  deserializer shift enable.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en`  out  1 each  checker enables.
- `data_valid`  out  1  one-cycle pulse; frame accepted.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Check strobe `chk` = (`edge_cnt` == `prescale`/2 + 2). This is the first cycle after the sampler's majority result is stable.
- IDLE: all outputs 0. `rx_in`==0 → START. `par_en` is latched into `par_en_q` on this transition.
- START:
  - Outputs: `edge_bit_counter_enable`=1, `dat_samp_en`=1, `strt_chk_en`=1.
  - At `chk` with `strt_glitch`=1 → IDLE. The counter is cleared next cycle.
  - Otherwise, `bit_cnt`==1 → DATA.
- DATA:
  - Counter and sampler enabled. `deser_en`=1 on `chk` cycles only, so there is exactly one shift per bit.
  - `bit_cnt`==DATA_BITS+1 → PARITY if `par_en_q`, else STOP.
- PARITY: `par_chk_en`=1. `err_q` |= `par_err` at `chk`. `bit_cnt`==DATA_BITS+2 → STOP.
- STOP: `stp_chk_en`=1. `err_q` |= `stp_err` at `chk`. `edge_cnt`==`prescale`-1 → DONE.
- DONE:
  - One cycle. `edge_bit_counter_enable`=0, which clears the counter.
  - `data_valid` = !`err_q`. `err_q` is cleared.
  - Next state: START if `rx_in`==0 (back-to-back frame, `par_en_q` relatched), else IDLE.
- Outputs are decoded from state plus counter inputs; there is no output register.

## Timing
- Reset: state IDLE, `err_q`=0, `par_en_q`=0, every output 0.
- `rx_in` falling edge to START: 1 cycle.
- `data_valid` occurs the cycle after the stop bit's `edge_cnt`==`prescale`-1.
- Frame length, START entry to DONE: about (DATA_BITS + 2 + `par_en`) × `prescale` cycles, plus 1 for the DONE cycle.
- `par_en` changing mid-frame has no effect until the next START entry.
- `rst` asserted mid-frame → IDLE immediately, all outputs 0. No `data_valid` is issued for the aborted frame.
- Errors in parity and stop in the same frame → a single suppressed `data_valid`.
- `prescale` changes mid-frame are illegal and the behaviour is undefined.

## Configuration
- `UART_RX_ERR_FLAGS_EN` defined:
  - Adds outputs `par_err_flag` and `stp_err_flag`, 1 bit each.
  - Each pulses in DONE when its error was latched in that frame.
  - Reset value 0.
- `UART_RX_ERR_FLAGS_EN` undefined: these ports and their separate latches are absent. Errored frames only suppress `data_valid`.

## Structure
- Shared package `uart_rx_pkg` holds:
  - the state enum and its width;
  - the default `DATA_BITS`;
  - the legal prescale constants 8/16/32.
- One sub-module is natural: `uart_rx_strobe_gen`. It decodes `chk` and end-of-bit (`edge_cnt`==`prescale`-1) from `edge_cnt`/`prescale`, and is reused by the checkers.

## Test plan
- `prescale`=8, `par_en`=0, byte 0xA5 with valid stop:
  - `deser_en` pulses exactly 8 times;
  - `data_valid` pulses once, 1 cycle after stop bit end;
  - FSM returns to IDLE.
- `prescale`=16, `par_en`=1, even parity, byte 0x3C with correct parity → `data_valid`=1. Same frame with parity flipped → no `data_valid`, and `par_err_flag`=1 when the macro is defined.
- `rx_in` low for only 3 cycles at `prescale`=8 → `strt_glitch` at `chk` returns the FSM to IDLE; counter enable drops; no `deser_en`.
- Stop bit driven 0, `prescale`=8 → no `data_valid`; `stp_err_flag`=1 when the macro is defined.
- Two back-to-back frames 0x01 and 0xFF, `prescale`=32 → two `data_valid` pulses, with no IDLE cycle between the frames.
- `rst` asserted during data bit 4 → all outputs 0 the same cycle. A following good frame 0x55 → `data_valid`=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver slice: FSM state codes,
// default frame width and the legal oversampling ratios.
package uart_rx_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

  typedef logic [STATE_W-1:0] state_t;

  localparam int DATA_BITS_DEF = 8;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_strobe_gen.sv
// Decodes the per-bit check strobe (majority result settled) and
// the end-of-bit strobe from the edge counter.
module uart_rx_strobe_gen #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      chk,
  output logic                      bit_end
);

  logic [PRESCALE_WIDTH-1:0] chk_pt;
  logic [PRESCALE_WIDTH-1:0] end_pt;

  assign chk_pt  = (prescale >> 1) + PRESCALE_WIDTH'(2);
  assign end_pt  = prescale - PRESCALE_WIDTH'(1);
  assign chk     = (edge_cnt == chk_pt);
  assign bit_end = (edge_cnt == end_pt);

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX control FSM: sequences one frame and issues data_valid.
// Optional UART_RX_ERR_FLAGS_EN adds per-frame parity/stop error pulses.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6,
  parameter int DATA_BITS      = DATA_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic                      par_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [3:0]                bit_cnt,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic                      edge_bit_counter_enable,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
`ifdef UART_RX_ERR_FLAGS_EN
  output logic                      par_err_flag,
  output logic                      stp_err_flag,
`endif
  output logic                      data_valid
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS + 1);
  localparam logic [3:0] LAST_PAR  = 4'(DATA_BITS + 2);

  state_t state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   err_q, err_d;
  logic   chk, bit_end;

`ifdef UART_RX_ERR_FLAGS_EN
  logic perr_q, perr_d;
  logic serr_q, serr_d;

  assign par_err_flag = (state_q == ST_DONE) & perr_q;
  assign stp_err_flag = (state_q == ST_DONE) & serr_q;
`endif

  uart_rx_strobe_gen #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_strobe (
    .prescale (prescale),
    .edge_cnt (edge_cnt),
    .chk      (chk),
    .bit_end  (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    err_d    = err_q;
`ifdef UART_RX_ERR_FLAGS_EN
    perr_d   = perr_q;
    serr_d   = serr_q;
`endif
    edge_bit_counter_enable = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_in) begin
          state_d  = ST_START;
          par_en_d = par_en;
        end
      end
      ST_START: begin
        edge_bit_counter_enable = 1'b1;
        dat_samp_en = 1'b1;
        strt_chk_en = 1'b1;
        if (chk && strt_glitch) begin
          state_d = ST_IDLE;
        end else if (bit_cnt == 4'd1) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        edge_bit_counter_enable = 1'b1;
        dat_samp_en = 1'b1;
        deser_en    = chk;
        if (bit_cnt == LAST_DATA) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        edge_bit_counter_enable = 1'b1;
        dat_samp_en = 1'b1;
        par_chk_en  = 1'b1;
        if (chk) begin
          err_d = err_q | par_err;
`ifdef UART_RX_ERR_FLAGS_EN
          perr_d = perr_q | par_err;
`endif
        end
        if (bit_cnt == LAST_PAR) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        edge_bit_counter_enable = 1'b1;
        dat_samp_en = 1'b1;
        stp_chk_en  = 1'b1;
        if (chk) begin
          err_d = err_q | stp_err;
`ifdef UART_RX_ERR_FLAGS_EN
          serr_d = serr_q | stp_err;
`endif
        end
        if (bit_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        data_valid = ~err_q;
        err_d      = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
        perr_d     = 1'b0;
        serr_d     = 1'b0;
`endif
        // A low line here is already the next frame's start bit.
        if (!rx_in) begin
          state_d  = ST_START;
          par_en_d = par_en;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      par_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
      err_q    <= err_d;
    end
  end

`ifdef UART_RX_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
      serr_q <= serr_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm with behavioural counter, sampler,
// deserializer and checkers around it; frames scored at DONE.
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic [5:0] ps = 6'd8;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_glitch, par_err, stp_err;
  logic       en, samp_en, deser_en, strt_en, par_en_o, stp_en, dv;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       pflag, sflag;
`endif

  always #5 clk = ~clk;

  uart_rx_fsm #(
    .PRESCALE_WIDTH (6),
    .DATA_BITS      (8)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .rx_in                   (rx_in),
    .par_en                  (par_en),
    .prescale                (ps),
    .edge_cnt                (edge_cnt),
    .bit_cnt                 (bit_cnt),
    .strt_glitch             (strt_glitch),
    .par_err                 (par_err),
    .stp_err                 (stp_err),
    .edge_bit_counter_enable (en),
    .dat_samp_en             (samp_en),
    .deser_en                (deser_en),
    .strt_chk_en             (strt_en),
    .par_chk_en              (par_en_o),
    .stp_chk_en              (stp_en),
`ifdef UART_RX_ERR_FLAGS_EN
    .par_err_flag            (pflag),
    .stp_err_flag            (sflag),
`endif
    .data_valid              (dv)
  );

  // Environment: edge/bit counter, mid-bit sampler, deserializer.
  logic       samp;
  logic [7:0] dsh;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      samp     <= 1'b1;
      dsh      <= '0;
    end else begin
      if (!en) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (edge_cnt == ps - 6'd1) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
      if (en && edge_cnt == (ps >> 1)) samp <= rx_in;
      if (deser_en) dsh <= {samp, dsh[7:1]};
    end
  end

  assign strt_glitch = samp;
  assign stp_err     = ~samp;
  assign par_err     = (^dsh) ^ samp;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       pe;
    logic       se;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   deser_n = 0;
  int   en_cyc = 0;
  int   b2b_left = 0;
  logic pend_b2b = 1'b0;
  logic prev_stp = 1'b0;
  int   prev_edge = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic int outs();
    int o;
    o = int'({en, samp_en, deser_en, strt_en, par_en_o, stp_en, dv});
`ifdef UART_RX_ERR_FLAGS_EN
    o = o | (int'(pflag) << 8) | (int'(sflag) << 9);
`endif
    return o;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_stp = 1'b0;
      deser_n  = 0;
      pend_b2b = 1'b0;
    end else begin
      if (deser_en) deser_n++;
      if (en) en_cyc++;
      if (pend_b2b) begin
        chk("b2b_no_idle", int'(en), 1);
        pend_b2b = 1'b0;
      end
      if (prev_stp && !stp_en) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data_valid", int'(dv), int'(e.v));
          chk("byte", int'(dsh), int'(e.d));
          chk("deser_pulses", deser_n, 8);
          chk("dv_timing", prev_edge, int'(ps) - 1);
`ifdef UART_RX_ERR_FLAGS_EN
          chk("par_err_flag", int'(pflag), int'(e.pe));
          chk("stp_err_flag", int'(sflag), int'(e.se));
`endif
        end
        deser_n = 0;
        if (b2b_left > 0) begin
          pend_b2b = 1'b1;
          b2b_left--;
        end
      end else if (dv) begin
        chk("dv_spurious", int'(dv), 0);
      end
      prev_stp  = stp_en;
      prev_edge = int'(edge_cnt);
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (int'(ps)) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe,
                            input logic flip, input logic stop_v,
                            input logic drop_pe);
    exp_t e;
    e.v  = ~(pe & flip) & stop_v;
    e.d  = d;
    e.pe = pe & flip;
    e.se = ~stop_v;
    sb.push_back(e);
    par_en = pe;
    send_bit(1'b0);
    if (drop_pe) par_en = ~pe;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit((^d) ^ flip);
    send_bit(stop_v);
    rx_in = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("sb_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", outs(), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_outs", outs(), 0);

    ps = 6'd8;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done();
    chk("idle_after_a5", outs(), 0);

    ps = 6'd16;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done();
    chk("idle_after_par", outs(), 0);

    ps = 6'd8;
    en_cyc  = 0;
    deser_n = 0;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    chk("glitch_en_cycles", en_cyc, int'(ps >> 1) + 3);
    chk("glitch_deser", deser_n, 0);
    chk("glitch_outs", outs(), 0);

    par_en = 1'b0;
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done();
    chk("idle_after_stp", outs(), 0);

    ps = 6'd32;
    b2b_left = 1;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done();
    chk("b2b_consumed", b2b_left, 0);

    ps = 6'd8;
    par_en = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_abort_en", int'(en), 1);
    rst = 1'b0;
    #1;
    chk("abort_outs", outs(), 0);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
